int_seq_ctrl: RTL

Pipeline front-end sequencer that owns the fetch stage's pc_select and the fetch/decode buffer enable and flush. It runs the reset-vector load after rst and the hardware interrupt entry sequence: drain, push return PC, push flags, then vector through the IVT. It also tracks in-ISR status until RTI commits. It sits beside the fetch stage and drives the memory stage's interrupt push request.

---
 rtl/int_seq_ctrl_pkg.sv | 27 ++
 rtl/int_seq_ctrl_drain_counter.sv | 26 ++
 rtl/int_seq_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/int_seq_ctrl_pkg.sv
// Shared definitions for the interrupt/reset front-end sequencer.
// State encoding, pc_select codes, push selectors, drain helper.
package int_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_VEC  = 3'd0,
    RUN      = 3'd1,
    DRAIN    = 3'd2,
    PUSH_PC  = 3'd3,
    PUSH_FLG = 3'd4,
    VECTOR   = 3'd5
  } seqState_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_IVT = 2'b01;
  localparam logic [1:0] PC_RET = 2'b10;
  localparam logic [1:0] PC_RST = 2'b11;

  localparam logic PUSH_PC_SEL  = 1'b0;
  localparam logic PUSH_FLG_SEL = 1'b1;

  // Counter preload so DRAIN lasts exactly `cycles` cycles.
  function automatic logic [3:0] drainInit(int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/int_seq_ctrl_drain_counter.sv
// Loadable 4-bit down-counter with zero flag for the drain phase.
// Ports: clk, rst (sync high), load/loadVal, dec -> zero.
module drain_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] loadVal,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/int_seq_ctrl.sv
// Front-end sequencer: reset vector load and interrupt entry.
// In: int_req/index, stall, mem_ack, rti_done. Out: fetch ctl, push, ack.
module int_seq_ctrl
  import int_seq_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int IDX_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_req,
  input  logic [IDX_W-1:0] int_index,
  input  logic             stall_req,
  input  logic             mem_ack,
  input  logic             rti_done,
  output logic [1:0]       pc_select,
  output logic             fetch_en,
  output logic             flush_fd,
  output logic             int_push,
  output logic             push_sel,
  output logic [IDX_W-1:0] ivt_index,
  output logic             int_ack,
  output logic             in_isr
);

  localparam logic [3:0] DRAIN_INIT = drainInit(DRAIN_CYCLES);

  seqState_t state;
  logic      accept;
  logic      drainZero;
  logic      cntDec;

  assign accept = (state == RUN) && int_req
               && !in_isr && !stall_req;
  assign cntDec = (state == DRAIN) && !drainZero;

  drain_counter uDrain (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .dec     (cntDec),
    .loadVal (DRAIN_INIT),
    .zero    (drainZero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_VEC;
      ivt_index <= '0;
      int_ack   <= 1'b0;
      in_isr    <= 1'b0;
    end else begin
      int_ack <= 1'b0;
      if (state == VECTOR) begin
        in_isr <= 1'b1;
      end else if (rti_done) begin
        in_isr <= 1'b0;
      end
      unique case (state)
        RST_VEC: state <= RUN;
        RUN: begin
          if (accept) begin
            ivt_index <= int_index;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drainZero) state <= PUSH_PC;
        end
        PUSH_PC: begin
          if (mem_ack) state <= PUSH_FLG;
        end
        PUSH_FLG: begin
          if (mem_ack) begin
            state   <= VECTOR;
            int_ack <= 1'b1;
          end
        end
        VECTOR:  state <= RUN;
        default: state <= RST_VEC;
      endcase
    end
  end

  // fetch_en in RST_VEC follows rst so the vector fetch
  // is enabled only once rst has been released.
  always_comb begin
    pc_select = PC_SEQ;
    fetch_en  = 1'b0;
    flush_fd  = 1'b1;
    int_push  = 1'b0;
    push_sel  = PUSH_PC_SEL;
    unique case (1'b1)
      (state == RST_VEC): begin
        pc_select = PC_RST;
        fetch_en  = ~rst;
      end
      (state == RUN): begin
        fetch_en = ~stall_req;
        flush_fd = 1'b0;
      end
      (state == DRAIN): ;
      (state == PUSH_PC): begin
        int_push = 1'b1;
      end
      (state == PUSH_FLG): begin
        int_push = 1'b1;
        push_sel = PUSH_FLG_SEL;
      end
      (state == VECTOR): begin
        pc_select = PC_IVT;
        fetch_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
